chan_phase_center_loader: RTL and testbench

Sequencer that turns the single 32-bit software-written phase-center command word into single-cycle writes to the per-channel phase-center RAM used by the channel packetizer. A toggle bit in the word marks each new command. Writes are held off for any cycle in which the packetizer is reading the same RAM address. An optional bulk clear sweeps every channel to zero. It sits in the fabric clock domain between the phase-center register output and the RAM write port.

---
 rtl/chan_phase_center_loader.sv | 153 +++++++++++++++
 tb/tb_chan_phase_center_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_phase_center_loader.sv
// Phase-center loader: turns toggle-marked command words into single-cycle RAM writes,
// stalling on read collisions. Define PHC_LOADER_CLEAR_EN to build the bulk-clear sweep.
module chan_phase_center_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              user_clk,
    input  logic              OPB_Rst,
    input  logic [31:0]       cmd_word,
    input  logic              dp_rd_en,
    input  logic [ADDR_W-1:0] dp_rd_addr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              loader_busy,
    output logic [15:0]       cmd_count,
    output logic              err_overrun
);

`ifdef PHC_LOADER_CLEAR_EN
    typedef enum logic [1:0] {PRIME, IDLE, WRITE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {PRIME, IDLE, WRITE} state_t;
`endif

    state_t              state_q, state_d;
    logic                tog_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                cmd_seen;
    logic                latch_cmd;
    logic                we_d;
    logic                count_inc;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                collide_wr;
    logic                unused_cmd_bits;

    // Only some command bits are decoded; fold the rest so they are visibly consumed.
    assign unused_cmd_bits = ^cmd_word;

    // PRIME masks the first comparison so a toggle already high at reset release is ignored.
    assign cmd_seen   = (state_q != PRIME) && (cmd_word[31] != tog_q);
    assign collide_wr = dp_rd_en && (dp_rd_addr == wr_addr_q);
    assign loader_busy = (state_q != IDLE);

`ifdef PHC_LOADER_CLEAR_EN
    // Extra top bit marks "all channels written" so the final cycle can retire the command.
    logic [ADDR_W:0] sweep_q;
    logic            start_clear;
    logic            sweep_inc;
    logic            collide_sw;

    assign collide_sw = dp_rd_en && (dp_rd_addr == sweep_q[ADDR_W-1:0]);

    always_ff @(posedge user_clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            sweep_q <= '0;
        end else if (start_clear) begin
            sweep_q <= '0;
        end else if (sweep_inc) begin
            sweep_q <= sweep_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        latch_cmd = 1'b0;
        we_d      = 1'b0;
        count_inc = 1'b0;
        sel_addr  = wr_addr_q;
        sel_data  = wr_data_q;
`ifdef PHC_LOADER_CLEAR_EN
        start_clear = 1'b0;
        sweep_inc   = 1'b0;
`endif
        case (state_q)
            PRIME: state_d = IDLE;
            IDLE: begin
                if (cmd_seen) begin
`ifdef PHC_LOADER_CLEAR_EN
                    if (cmd_word[30]) begin
                        start_clear = 1'b1;
                        state_d     = CLEAR;
                    end else begin
                        latch_cmd = 1'b1;
                        state_d   = WRITE;
                    end
`else
                    latch_cmd = 1'b1;
                    state_d   = WRITE;
`endif
                end
            end
            WRITE: begin
                if (!collide_wr) begin
                    we_d      = 1'b1;
                    count_inc = 1'b1;
                    state_d   = IDLE;
                end
            end
`ifdef PHC_LOADER_CLEAR_EN
            CLEAR: begin
                sel_addr = sweep_q[ADDR_W-1:0];
                sel_data = '0;
                if (sweep_q[ADDR_W]) begin
                    count_inc = 1'b1;
                    state_d   = IDLE;
                end else if (!collide_sw) begin
                    we_d      = 1'b1;
                    sweep_inc = 1'b1;
                end
            end
`endif
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge user_clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q     <= PRIME;
            tog_q       <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            cmd_count   <= '0;
            err_overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            tog_q   <= cmd_word[31];
            ram_we  <= we_d;
            if (latch_cmd) begin
                wr_addr_q <= cmd_word[16 +: ADDR_W];
                wr_data_q <= cmd_word[DATA_W-1:0];
            end
            if (we_d) begin
                ram_addr <= sel_addr;
                ram_din  <= sel_data;
            end
            if (count_inc) begin
                cmd_count <= cmd_count + 16'd1;
            end
            // A command seen while busy is dropped; tog_q has already moved past it.
            if (cmd_seen && (state_q != IDLE)) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chan_phase_center_loader.sv
// Self-checking bench for chan_phase_center_loader: a job-queue model predicts every output
// each cycle, and directed scenarios pin latency, collision stalls, overrun and reset.
module tb_chan_phase_center_loader;

    logic        user_clk = 1'b0;
    logic        OPB_Rst  = 1'b1;
    logic [31:0] cmd_word = 32'h8000_0000;
    logic        dp_rd_en = 1'b0;
    logic [7:0]  dp_rd_addr = 8'h00;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        loader_busy;
    logic [15:0] cmd_count;
    logic        err_overrun;

    chan_phase_center_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .user_clk    (user_clk),
        .OPB_Rst     (OPB_Rst),
        .cmd_word    (cmd_word),
        .dp_rd_en    (dp_rd_en),
        .dp_rd_addr  (dp_rd_addr),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .loader_busy (loader_busy),
        .cmd_count   (cmd_count),
        .err_overrun (err_overrun)
    );

    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef PHC_LOADER_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    // Model: each accepted command becomes a list of pending jobs. A write job retires on the
    // first edge its address is not being read; a clear adds 256 zero writes plus one retire step.
    typedef struct {
        bit          is_write;
        logic [7:0]  addr;
        logic [15:0] data;
        bit          bump;
    } job_t;

    job_t        jq[$];
    job_t        head;
    job_t        nj;
    bit          m_prime = 1'b1;
    logic        m_tog   = 1'b0;
    logic        m_we    = 1'b0;
    logic [7:0]  m_addr  = 8'h00;
    logic [15:0] m_din   = 16'h0000;
    logic [15:0] m_count = 16'h0000;
    logic        m_err   = 1'b0;
    bit          busy_before;
    bit          new_cmd;

    always @(posedge user_clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            m_prime = 1'b1;
            m_tog   = 1'b0;
            jq.delete();
            m_we    = 1'b0;
            m_addr  = 8'h00;
            m_din   = 16'h0000;
            m_count = 16'h0000;
            m_err   = 1'b0;
        end else if (m_prime) begin
            m_prime = 1'b0;
            m_tog   = cmd_word[31];
            m_we    = 1'b0;
        end else begin
            busy_before = (jq.size() != 0);
            new_cmd     = (cmd_word[31] != m_tog);
            m_tog       = cmd_word[31];
            m_we        = 1'b0;
            if (busy_before) begin
                head = jq[0];
                if (!head.is_write) begin
                    m_count = m_count + 16'd1;
                    void'(jq.pop_front());
                end else if (!(dp_rd_en && dp_rd_addr == head.addr)) begin
                    m_we   = 1'b1;
                    m_addr = head.addr;
                    m_din  = head.data;
                    if (head.bump) m_count = m_count + 16'd1;
                    void'(jq.pop_front());
                end
            end
            if (new_cmd) begin
                if (busy_before) begin
                    m_err = 1'b1;
                end else if (CLEAR_EN && cmd_word[30]) begin
                    for (int a = 0; a < 256; a++) begin
                        nj.is_write = 1'b1; nj.addr = 8'(a); nj.data = 16'h0000; nj.bump = 1'b0;
                        jq.push_back(nj);
                    end
                    nj.is_write = 1'b0; nj.addr = 8'h00; nj.data = 16'h0000; nj.bump = 1'b1;
                    jq.push_back(nj);
                end else begin
                    nj.is_write = 1'b1; nj.addr = cmd_word[23:16]; nj.data = cmd_word[15:0]; nj.bump = 1'b1;
                    jq.push_back(nj);
                end
            end
        end
    end

    always @(negedge user_clk) begin
        if (chk_en) begin
            check("ram_we",      {31'd0, ram_we},      {31'd0, m_we});
            check("ram_addr",    {24'd0, ram_addr},    {24'd0, m_addr});
            check("ram_din",     {16'd0, ram_din},     {16'd0, m_din});
            check("loader_busy", {31'd0, loader_busy}, {31'd0, (m_prime || jq.size() != 0)});
            check("cmd_count",   {16'd0, cmd_count},   {16'd0, m_count});
            check("err_overrun", {31'd0, err_overrun}, {31'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    logic tog = 1'b1;

    // Issue one command, optionally reading rd_a for rd_cycles cycles after decode,
    // and report the number of edges until ram_we plus the values written.
    task automatic run_cmd(input logic [31:0] w, input int rd_cycles, input logic [7:0] rd_a,
                           output int lat, output logic [7:0] a, output logic [15:0] d);
        cmd_word = w;
        lat = -1;
        a   = 8'h00;
        d   = 16'h0000;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (k <= rd_cycles) begin
                dp_rd_en   = 1'b1;
                dp_rd_addr = rd_a;
            end else begin
                dp_rd_en = 1'b0;
            end
            if (ram_we && lat < 0) begin
                lat = k;
                a   = ram_addr;
                d   = ram_din;
            end
            if (lat >= 0 && !loader_busy) break;
        end
        dp_rd_en = 1'b0;
    endtask

    int          lat;
    logic [7:0]  cap_a;
    logic [15:0] cap_d;
    int          n_we;
    int          n_busy;
    bit          order_ok;
    bit          stalled;
    bit          hit;

    initial begin
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        OPB_Rst = 1'b0;

        // Toggle bit already high at release must not produce a write.
        repeat (3) tick();
        check("prime_no_cmd_busy",  {31'd0, loader_busy}, 32'd0);
        check("prime_no_cmd_count", {16'd0, cmd_count},  32'd0);

        tog = ~tog;
        run_cmd({tog, 1'b0, 6'd0, 8'h12, 16'h1A2B}, 0, 8'h00, lat, cap_a, cap_d);
        check("single_latency", lat, 32'd2);
        check("single_addr", {24'd0, cap_a}, 32'h12);
        check("single_data", {16'd0, cap_d}, 32'h1A2B);
        check("single_count", {16'd0, cmd_count}, 32'd1);

        tog = ~tog;
        run_cmd({tog, 1'b0, 6'd0, 8'h12, 16'h1A2B}, 3, 8'h12, lat, cap_a, cap_d);
        check("collide_latency", lat, 32'd5);
        check("collide_addr", {24'd0, cap_a}, 32'h12);
        check("collide_count", {16'd0, cmd_count}, 32'd2);

        tog = ~tog;
        run_cmd({tog, 1'b0, 6'd0, 8'h12, 16'h0F0F}, 3, 8'h13, lat, cap_a, cap_d);
        check("neighbour_latency", lat, 32'd2);
        check("neighbour_data", {16'd0, cap_d}, 32'h0F0F);
        check("neighbour_count", {16'd0, cmd_count}, 32'd3);

`ifdef PHC_LOADER_CLEAR_EN
        tog = ~tog;
        cmd_word = {tog, 1'b1, 6'd0, 8'h00, 16'hFFFF};
        n_we = 0; n_busy = 0; order_ok = 1'b1; stalled = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            tick();
            dp_rd_en = 1'b0;
            if (loader_busy) n_busy++;
            if (ram_we) begin
                if (ram_addr != 8'(n_we) || ram_din != 16'h0000) order_ok = 1'b0;
                n_we++;
                if (ram_addr == 8'h3F && !stalled) begin
                    dp_rd_en   = 1'b1;
                    dp_rd_addr = 8'h40;
                    stalled    = 1'b1;
                end
            end
            if (k == 10) begin
                tog = ~tog;
                cmd_word = {tog, 1'b0, 6'd0, 8'h05, 16'h0555};
            end
            if (k > 2 && !loader_busy) break;
        end
        dp_rd_en = 1'b0;
        check("clear_writes", n_we, 32'd256);
        check("clear_order", {31'd0, order_ok}, 32'd1);
        check("clear_busy_cycles", n_busy, 32'd258);
        check("clear_count", {16'd0, cmd_count}, 32'd4);
        check("clear_overrun", {31'd0, err_overrun}, 32'd1);
        repeat (5) tick();
        check("overrun_sticky", {31'd0, err_overrun}, 32'd1);

        tog = ~tog;
        cmd_word = {tog, 1'b1, 6'd0, 8'h00, 16'h0000};
        hit = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            tick();
            if (ram_we && ram_addr == 8'h7F) begin
                OPB_Rst = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        check("reset_reached_0x80", {31'd0, hit}, 32'd1);
`else
        tog = ~tog;
        cmd_word = {tog, 1'b1, 6'd0, 8'h21, 16'h2121};
        tick();
        tog = ~tog;
        cmd_word = {tog, 1'b0, 6'd0, 8'h22, 16'h2222};
        repeat (3) tick();
        check("overrun_flag", {31'd0, err_overrun}, 32'd1);
        check("overrun_count", {16'd0, cmd_count}, 32'd4);
        check("overrun_addr", {24'd0, ram_addr}, 32'h21);
        repeat (5) tick();
        check("overrun_sticky", {31'd0, err_overrun}, 32'd1);

        dp_rd_en = 1'b1;
        dp_rd_addr = 8'h33;
        tog = ~tog;
        cmd_word = {tog, 1'b0, 6'd0, 8'h33, 16'h3333};
        repeat (3) tick();
        OPB_Rst = 1'b1;
`endif
        #1;
        check("rst_we",    {31'd0, ram_we},      32'd0);
        check("rst_addr",  {24'd0, ram_addr},    32'd0);
        check("rst_din",   {16'd0, ram_din},     32'd0);
        check("rst_busy",  {31'd0, loader_busy}, 32'd1);
        check("rst_count", {16'd0, cmd_count},   32'd0);
        check("rst_err",   {31'd0, err_overrun}, 32'd0);
        repeat (3) tick();
        dp_rd_en = 1'b0;
        OPB_Rst  = 1'b0;
        n_we = 0;
        repeat (30) begin
            tick();
            if (ram_we) n_we++;
        end
        check("no_write_after_rst", n_we, 32'd0);

        // Random traffic: small address range so reads often collide with pending writes.
        for (int i = 0; i < 1500; i++) begin
            dp_rd_en   = ($urandom_range(0, 1) == 1);
            dp_rd_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                tog = ~tog;
                cmd_word = {tog, ($urandom_range(0, 19) == 0), 6'($urandom()),
                            8'($urandom_range(0, 7)), 16'($urandom())};
            end
            tick();
        end
        dp_rd_en = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (!loader_busy) begin
                hit = 1'b1;
                break;
            end
        end
        check("drain_idle", {31'd0, hit}, 32'd1);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
